// File: rtl/cram_pkg.sv
// rtl/cram_pkg.sv - shared types and widths for the color RAM write scheduler
package cram_pkg;

  localparam int CRAM_ADDR_W = 5;
  localparam int CRAM_DATA_W = 9;
  localparam int CRAM_ENTRY_W = CRAM_ADDR_W + CRAM_DATA_W;

  typedef struct packed {
    logic [CRAM_ADDR_W-1:0] addr;
    logic [CRAM_DATA_W-1:0] data;
  } cram_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } cram_state_e;

endpackage

// File: rtl/cram_wr_fifo.sv
// rtl/cram_wr_fifo.sv - pending CPU write FIFO with tail compare and in-place tail overwrite
module cram_wr_fifo
  import cram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [CRAM_ENTRY_W-1:0]       push_entry_i,
  input  logic                          ovw_i,
  input  logic [CRAM_DATA_W-1:0]        ovw_data_i,
  output logic [CRAM_ENTRY_W-1:0]       head_o,
  output logic [CRAM_ADDR_W-1:0]        tail_addr_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cram_entry_t       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     tail_ptr;

  assign tail_ptr    = wr_ptr_q - PW'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign tail_addr_o = mem_q[tail_ptr].addr;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= cram_entry_t'(push_entry_i);
    end else if (ovw_i) begin
      mem_q[tail_ptr].data <= ovw_data_i;
    end
  end

endmodule

// File: rtl/cram_write_scheduler.sv
// rtl/cram_write_scheduler.sv - defers CPU color RAM writes to blanking; CRAM_COALESCE_EN merges same-address tail writes
module cram_write_scheduler
  import cram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce5,
  input  logic       cpu_wr,
  input  logic [5:0] cpu_ba,
  input  logic [7:0] cpu_bd,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [4:0] pix_addr,
  output logic       ram_we,
  output logic [4:0] ram_addr,
  output logic [8:0] ram_din,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  cram_state_e               state_q, state_d;
  logic                      ram_we_q;
  logic [CRAM_ADDR_W-1:0]    wr_addr_q;
  logic [CRAM_DATA_W-1:0]    wr_data_q;
  logic                      overflow_q;

  logic                      blank;
  logic                      pop, push, coalesce, drop;
  logic                      fifo_empty, fifo_full_w;
  logic [CW-1:0]             fifo_count;
  logic [CRAM_ENTRY_W-1:0]   head_w;
  cram_entry_t               head;
  logic [CRAM_ADDR_W-1:0]    tail_addr;
  logic [CRAM_DATA_W-1:0]    cpu_data;

  assign blank    = hblank | vblank;
  assign cpu_data = {cpu_ba[5], cpu_bd};
  assign head     = cram_entry_t'(head_w);
  assign pop      = (state_q == DRAIN) & ce5 & blank & ~fifo_empty;

`ifdef CRAM_COALESCE_EN
  // A tail that leaves this clk cannot be merged into; the write becomes a fresh entry.
  assign coalesce = cpu_wr & ~fifo_empty & (tail_addr == cpu_ba[4:0])
                  & ~(pop & (fifo_count == CW'(1)));
`else
  logic unused_tail;
  assign unused_tail = ^{tail_addr, fifo_count};
  assign coalesce    = 1'b0;
`endif

  assign push = cpu_wr & ~coalesce & (~fifo_full_w | pop);
  assign drop = cpu_wr & ~coalesce & fifo_full_w & ~pop;

  cram_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i ({cpu_ba[4:0], cpu_data}),
    .ovw_i        (coalesce),
    .ovw_data_i   (cpu_data),
    .head_o       (head_w),
    .tail_addr_o  (tail_addr),
    .full_o       (fifo_full_w),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  // Blank transitions only count on pixel-enable clks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = WAIT;
      WAIT:    if (ce5 && blank) state_d = DRAIN;
      DRAIN: begin
        if (fifo_empty)         state_d = IDLE;
        else if (ce5 && !blank) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_we_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_we_q   <= pop;
      overflow_q <= overflow_q | drop;
      if (pop) begin
        wr_addr_q <= head.addr;
        wr_data_q <= head.data;
      end
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_we_q ? wr_addr_q : pix_addr;
  assign ram_din   = wr_data_q;
  assign fifo_full = fifo_full_w;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cram_write_scheduler.sv
// tb/tb_cram_write_scheduler.sv - scoreboard bench for the color RAM write scheduler
module tb_cram_write_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce5 = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [5:0] cpu_ba = '0;
  logic [7:0] cpu_bd = '0;
  logic       hblank = 1'b0;
  logic       vblank = 1'b0;
  logic [4:0] pix_addr = '0;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [8:0] ram_din;
  logic       fifo_full;
  logic       overflow;

  cram_write_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ce5(ce5), .cpu_wr(cpu_wr), .cpu_ba(cpu_ba),
    .cpu_bd(cpu_bd), .hblank(hblank), .vblank(vblank), .pix_addr(pix_addr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [8:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         wcyc[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         wr_seen = 0;
  logic [1:0] ce_div = '0;
  logic       prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ce5 fires every 4th clk; pixel address wanders every clk.
  always @(negedge clk) begin
    ce_div   = ce_div + 2'd1;
    ce5      = (ce_div == 2'd0);
    pix_addr = 5'($urandom);
  end

  always @(posedge clk) begin
    #1;
    if (ram_we) begin
      wr_seen++;
      wcyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h din=%h, expected no write", ram_addr, ram_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_addr !== mon_e.a || ram_din !== mon_e.d)
          $display("FAIL write_order: got addr=%h din=%h, expected addr=%h din=%h",
                   ram_addr, ram_din, mon_e.a, mon_e.d);
        else n_pass++;
      end
      n_checks++;
      if (prev_we !== 1'b0) $display("FAIL we_width: ram_we high two clks in a row");
      else n_pass++;
    end else if (!reset) begin
      n_checks++;
      if (ram_addr !== pix_addr)
        $display("FAIL addr_mux: got ram_addr=%h, expected pix_addr=%h", ram_addr, pix_addr);
      else n_pass++;
    end
    prev_we = ram_we;
  end

  task automatic cpu_write(input logic [5:0] ba, input logic [7:0] bd, input logic expect_push);
    exp_t e;
    @(negedge clk);
    cpu_wr = 1'b1;
    cpu_ba = ba;
    cpu_bd = bd;
    if (expect_push) begin
      e.a = ba[4:0];
      e.d = {ba[5], bd};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (wr_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if (ram_we !== 1'b0) $display("FAIL reset_we: got %b, expected 0", ram_we); else n_pass++;
    n_checks++;
    if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b, expected 0", fifo_full); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b, expected 0", overflow); else n_pass++;
    n_checks++;
    if (ram_din !== 9'h000) $display("FAIL reset_din: got %h, expected 000", ram_din); else n_pass++;
    n_checks++;
    if (ram_addr !== pix_addr) $display("FAIL reset_addr: got %h, expected %h", ram_addr, pix_addr); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    int base;
    bit ok;
    base = wr_seen;
    cpu_write(6'h25, 8'hA5, 1'b1);
    cpu_idle();
    repeat (20) @(posedge clk);
    #2;
    n_checks++;
    if (wr_seen !== base) $display("FAIL single_active: got %0d writes, expected 0", wr_seen - base); else n_pass++;
    @(negedge clk);
    hblank = 1'b1;
    wait_writes(base + 1, 50, ok);
    n_checks++;
    if (!ok) $display("FAIL single_timeout: got 0 writes, expected 1"); else n_pass++;
    repeat (12) @(posedge clk);
    #2;
    n_checks++;
    if (wr_seen !== base + 1) $display("FAIL single_count: got %0d writes, expected 1", wr_seen - base); else n_pass++;
    @(negedge clk);
    hblank = 1'b0;
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    base = wr_seen;
    for (int i = 0; i < 5; i++) begin
      cpu_write(6'(i), 8'h10 + 8'(i), (i < 4));
      if (i == 3) begin
        n_checks++;
        if (fifo_full !== 1'b1) $display("FAIL full_at_4: got %b, expected 1", fifo_full); else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_early: got %b, expected 0", overflow); else n_pass++;
      end
    end
    cpu_idle();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", overflow); else n_pass++;
    wcyc.delete();
    vblank = 1'b1;
    wait_writes(base + 4, 100, ok);
    n_checks++;
    if (!ok) $display("FAIL ovf_drain_timeout: got %0d writes, expected 4", wr_seen - base); else n_pass++;
    if (ok && wcyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (wcyc[i] - wcyc[i-1] !== 4)
          $display("FAIL drain_spacing: got %0d clks, expected 4", wcyc[i] - wcyc[i-1]);
        else n_pass++;
      end
    end
    repeat (12) @(posedge clk);
    #2;
    n_checks++;
    if (fifo_full !== 1'b0) $display("FAIL full_after_drain: got %b, expected 0", fifo_full); else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", overflow); else n_pass++;
    @(negedge clk);
    vblank = 1'b0;
  endtask

  task automatic test_push_during_drain();
    int base;
    int n_ce;
    bit ok;
    exp_t e;
    base = wr_seen;
    cpu_write(6'h03, 8'h31, 1'b1);
    cpu_write(6'h27, 8'h72, 1'b1);
    cpu_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    hblank = 1'b1;
    #1;
    n_ce = ce5 ? 1 : 0;
    for (int i = 0; i < 20 && n_ce < 2; i++) begin
      @(negedge clk);
      #1;
      if (ce5) n_ce++;
    end
    // Second ce5 after blank rises is the first pop clk.
    cpu_wr = 1'b1;
    cpu_ba = 6'h09;
    cpu_bd = 8'h99;
    e.a = 5'h09;
    e.d = 9'h099;
    exp_q.push_back(e);
    @(negedge clk);
    cpu_wr = 1'b0;
    wait_writes(base + 3, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL pushpop_timeout: got %0d writes, expected 3", wr_seen - base); else n_pass++;
    @(negedge clk);
    hblank = 1'b0;
  endtask

  task automatic test_blank_end_mid_drain();
    int base;
    bit ok;
    base = wr_seen;
    cpu_write(6'h10, 8'h01, 1'b1);
    cpu_write(6'h11, 8'h02, 1'b1);
    cpu_write(6'h32, 8'h03, 1'b1);
    cpu_idle();
    @(negedge clk);
    hblank = 1'b1;
    wait_writes(base + 1, 50, ok);
    @(negedge clk);
    hblank = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL midblank_first: got 0 writes, expected 1"); else n_pass++;
    repeat (30) @(posedge clk);
    #2;
    n_checks++;
    if (wr_seen !== base + 1) $display("FAIL midblank_held: got %0d writes, expected 1", wr_seen - base); else n_pass++;
    @(negedge clk);
    hblank = 1'b1;
    wait_writes(base + 3, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL midblank_resume: got %0d writes, expected 3", wr_seen - base); else n_pass++;
    @(negedge clk);
    hblank = 1'b0;
  endtask

  task automatic test_coalesce();
    int base;
    int n_exp;
    bit ok;
    base = wr_seen;
`ifdef CRAM_COALESCE_EN
    n_exp = 1;
    cpu_write(6'h0A, 8'h11, 1'b0);
`else
    n_exp = 2;
    cpu_write(6'h0A, 8'h11, 1'b1);
`endif
    cpu_write(6'h2A, 8'h22, 1'b1);
    cpu_idle();
    repeat (10) @(posedge clk);
    @(negedge clk);
    hblank = 1'b1;
    wait_writes(base + n_exp, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL coalesce_timeout: got %0d writes, expected %0d", wr_seen - base, n_exp); else n_pass++;
    repeat (20) @(posedge clk);
    #2;
    n_checks++;
    if (wr_seen - base !== n_exp)
      $display("FAIL coalesce_count: got %0d writes, expected %0d", wr_seen - base, n_exp);
    else n_pass++;
    @(negedge clk);
    hblank = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int base;
    bit ok;
    base = wr_seen;
    cpu_write(6'h1C, 8'hC1, 1'b1);
    cpu_write(6'h1D, 8'hC2, 1'b1);
    cpu_write(6'h1E, 8'hC3, 1'b1);
    cpu_idle();
    @(negedge clk);
    vblank = 1'b1;
    wait_writes(base + 1, 50, ok);
    n_checks++;
    if (!ok) $display("FAIL rstdrain_first: got 0 writes, expected 1"); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (ram_we !== 1'b0) $display("FAIL rstdrain_we: got %b, expected 0", ram_we); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL rstdrain_ovf: got %b, expected 0", overflow); else n_pass++;
    n_checks++;
    if (fifo_full !== 1'b0) $display("FAIL rstdrain_full: got %b, expected 0", fifo_full); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    base = wr_seen;
    repeat (40) @(posedge clk);
    #2;
    n_checks++;
    if (wr_seen !== base) $display("FAIL rstdrain_lost: got %0d writes, expected 0", wr_seen - base); else n_pass++;
    @(negedge clk);
    vblank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_push_during_drain();
    test_blank_end_mid_drain();
    test_coalesce();
    test_reset_mid_drain();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_left: got %0d pending, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
